// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pkg
// Description : Shared constants for the control unit: instruction opcodes,
//               ALU operation codes, FSM state encoding, instruction-class
//               enum and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

  // Instruction opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h3;
  localparam logic [3:0] ALU_MUL  = 4'h4;
  localparam logic [3:0] ALU_DIV  = 4'h6;
  localparam logic [3:0] ALU_SHR  = 4'h7;
  localparam logic [3:0] ALU_SHRA = 4'h8;
  localparam logic [3:0] ALU_SHL  = 4'h9;
  localparam logic [3:0] ALU_ROR  = 4'hA;
  localparam logic [3:0] ALU_ROL  = 4'hB;
  localparam logic [3:0] ALU_NEG  = 4'hC;
  localparam logic [3:0] ALU_NOT  = 4'hD;

  // FSM state encoding
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  // Execute-phase sequencing class of an instruction
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,  // nop and undefined opcodes
    CLS_BINARY = 3'd1,
    CLS_UNARY  = 3'd2,
    CLS_MULDIV = 3'd3,
    CLS_HALT   = 3'd4
  } instr_class_e;

  function automatic instr_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL: classify = CLS_BINARY;
      OP_NEG, OP_NOT:          classify = CLS_UNARY;
      OP_MUL, OP_DIV:          classify = CLS_MULDIV;
      OP_HALT:                 classify = CLS_HALT;
      OP_NOP:                  classify = CLS_NONE;
      default:                 classify = CLS_NONE;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_ROR:  alu_code = ALU_ROR;
      OP_ROL:  alu_code = ALU_ROL;
      OP_SHR:  alu_code = ALU_SHR;
      OP_SHRA: alu_code = ALU_SHRA;
      OP_SHL:  alu_code = ALU_SHL;
      OP_MUL:  alu_code = ALU_MUL;
      OP_DIV:  alu_code = ALU_DIV;
      OP_NEG:  alu_code = ALU_NEG;
      OP_NOT:  alu_code = ALU_NOT;
      default: alu_code = 4'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_decode_4to16.sv
`default_nettype none
// ============================================================================
// Module      : reg_decode_4to16
// Description : Enabled 4-to-16 one-hot decoder for GPR select lines.
//               Field value n selects bit n; all zeros when disabled.
// Ports       : en_i     - decode enable
//               sel_i    - 4-bit register number
//               onehot_o - one-hot select (at most one bit set)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_decode_4to16 (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] onehot_o
);

  assign onehot_o = en_i ? (16'h0001 << sel_i) : 16'h0000;

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Moore FSM sequencing fetch (T0-T2) and execute (T3-T6) of a
//               simple register-to-register datapath. Outputs decode from
//               the state register and IR only.
// Config      : MULDIV_EN - when defined, mul/div run a 4-step execute that
//               writes LO (T5) and HI (T6); otherwise mul/div behave as nop
//               and LOin/HIin/Zhighout are tied low.
// Ports       : Clock, Reset (sync, active high)
//               IR[31:0]   - opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//               Stop       - halt request
//               PCout..HIin- datapath strobes
//               Rout/Rin   - one-hot GPR drive / load selects
//               ALUop      - ALU operation, qualified by Zin
//               Run        - low only in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        IncPC,
  output logic        Read,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [3:0]  ALUop,
  output logic        Run
);

  logic [3:0]   state_q, state_d;
  logic         stop_q, stop_d;

  logic [4:0]   opcode;
  logic [3:0]   ra, rb, rc;
  instr_class_e cls_raw, cls;
  logic [3:0]   alu;

  logic         rout_en, rin_en, last;
  logic [3:0]   rout_sel;

  // Low IR bits carry no control information
  logic         unused_ir_bits;
  assign unused_ir_bits = ^IR[14:0];

  assign opcode  = IR[31:27];
  assign ra      = IR[26:23];
  assign rb      = IR[22:19];
  assign rc      = IR[18:15];
  assign cls_raw = classify(opcode);
  assign alu     = alu_code(opcode);

`ifdef MULDIV_EN
  assign cls = cls_raw;
`else
  // Without the multiplier/divider, mul/div retire as nop after T3
  assign cls = (cls_raw == CLS_MULDIV) ? CLS_NONE : cls_raw;
`endif

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ALUop    = 4'h0;
    rout_en  = 1'b0;
    rout_sel = rb;
    rin_en   = 1'b0;
    last     = 1'b0;
`ifdef MULDIV_EN
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
`endif

    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (cls)
          CLS_BINARY, CLS_MULDIV: begin
            rout_en = 1'b1;
            Yin     = 1'b1;
            state_d = S_T4;
          end
          CLS_UNARY: begin
            rout_en = 1'b1;
            ALUop   = alu;
            Zin     = 1'b1;
            state_d = S_T4;
          end
          CLS_HALT: state_d = S_HALT;
          default:  last    = 1'b1;
        endcase
      end
      S_T4: begin
        case (cls)
          CLS_BINARY, CLS_MULDIV: begin
            rout_en  = 1'b1;
            rout_sel = rc;
            ALUop    = alu;
            Zin      = 1'b1;
            state_d  = S_T5;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
            last    = 1'b1;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_BINARY: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
            last    = 1'b1;
          end
`ifdef MULDIV_EN
          CLS_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
            state_d = S_T6;
          end
`endif
          default: state_d = S_T0;
        endcase
      end
      S_T6: begin
`ifdef MULDIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
        last     = 1'b1;
`else
        state_d  = S_T0;
`endif
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase

    // A Stop seen anywhere during an instruction is held until that
    // instruction retires, so a short pulse before the final step still halts.
    if (last) begin
      state_d = (Stop || stop_q) ? S_HALT : S_T0;
    end
  end

  always_comb begin
    stop_d = stop_q;
    if (state_q >= S_T0 && state_q <= S_T6) begin
      stop_d = stop_q | Stop;
    end
    if (last) begin
      stop_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RST;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

`ifndef MULDIV_EN
  assign Zhighout = 1'b0;
  assign LOin     = 1'b0;
  assign HIin     = 1'b0;
`endif

  assign Run = (state_q != S_HALT);

  // Rin always targets Ra; Rout selects Rb or Rc depending on the step
  reg_decode_4to16 u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (Rout)
  );

  reg_decode_4to16 u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (ra),
    .onehot_o (Rin)
  );

endmodule
`default_nettype wire
